spi_target: RTL and testbench

SPI mode-0 target (peripheral) that answers the SoC's SPI master (`spi0_clk`/`spi0_mosi`/`spi0_miso`) from fabric logic. Used for board loopback tests and as a command port for on-FPGA test engines. SCK, MOSI and CS_n are oversampled in the `sys_clk` domain. The block is byte-oriented: each received byte comes out as a one-cycle pulse, and the next transmit byte is taken through a ready/valid handshake at every byte boundary.

---
 rtl/spi_pkg.sv | 13 +
 rtl/sync_edge.sv | 31 +++
 rtl/spi_target.sv | 172 +++++++++++++++++
 tb/tb_spi_target.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } spi_tgt_state_e;

    localparam int SPI_BITS_PER_BYTE = 8;
    localparam int SPI_CNT_W         = $clog2(SPI_BITS_PER_BYTE);

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with edge detect on the last two synchronized samples.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, oversampled in sys_clk; byte-wide rx pulse and tx ready/valid.
//
// state     | meaning
// WAIT_IDLE | after reset: let synchronizers fill, then wait for CS_n high
// IDLE      | CS_n high, waiting for its falling edge
// ACTIVE    | selected: shift on SCK edges, drive MISO
module spi_target
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic       cs_active
);

    localparam int                      SETTLE_W      = $clog2(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0]     SETTLE_CYCLES = SETTLE_W'(SYNC_STAGES + 1);
    localparam logic [SPI_CNT_W-1:0]    LAST_BIT      = SPI_CNT_W'(SPI_BITS_PER_BYTE - 1);

    logic sck_rise, sck_fall, sck_level_unused;
    logic cs_n_level, cs_n_fall, cs_n_rise_unused;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .d_i     (spi_clk),
        .level_o (sck_level_unused),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .d_i     (spi_cs_n),
        .level_o (cs_n_level),
        .rise_o  (cs_n_rise_unused),
        .fall_o  (cs_n_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .d_i     (spi_mosi),
        .level_o (mosi_level),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    spi_tgt_state_e                 state_q, state_d;
    logic [SETTLE_W-1:0]            settle_q, settle_d;
    logic [SPI_BITS_PER_BYTE-1:0]   txsh_q, txsh_d;
    logic [SPI_BITS_PER_BYTE-1:0]   rxsh_q, rxsh_d;
    logic [SPI_CNT_W-1:0]           bitcnt_q, bitcnt_d;
    logic                           byte_done_q, byte_done_d;
    logic                           miso_q, miso_d;
    logic [7:0]                     rx_data_q, rx_data_d;
    logic                           rx_valid_q, rx_valid_d;
    logic                           tx_load;
    logic [7:0]                     tx_byte;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= WAIT_IDLE;
            settle_q    <= SETTLE_CYCLES;
            txsh_q      <= '0;
            rxsh_q      <= '0;
            bitcnt_q    <= '0;
            byte_done_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            txsh_q      <= txsh_d;
            rxsh_q      <= rxsh_d;
            bitcnt_q    <= bitcnt_d;
            byte_done_q <= byte_done_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        txsh_d      = txsh_q;
        rxsh_d      = rxsh_q;
        bitcnt_d    = bitcnt_q;
        byte_done_d = byte_done_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_load     = 1'b0;
        tx_byte     = tx_valid ? tx_data : FILL_BYTE;

        unique case (state_q)
            WAIT_IDLE: begin
                // Synchronizers hold reset (idle) values until refilled from the pins;
                // trusting CS_n=1 before then would let a live transfer slip through.
                if (settle_q != '0) begin
                    settle_d = settle_q - SETTLE_W'(1);
                end else if (cs_n_level) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_n_fall) begin
                    state_d     = ACTIVE;
                    tx_load     = 1'b1;
                    txsh_d      = tx_byte;
                    miso_d      = tx_byte[7];
                    bitcnt_d    = '0;
                    byte_done_d = 1'b0;
                    rxsh_d      = '0;
                end
            end
            ACTIVE: begin
                if (cs_n_level) begin
                    state_d     = IDLE;
                    bitcnt_d    = '0;
                    byte_done_d = 1'b0;
                    miso_d      = 1'b0;
                end else if (sck_rise) begin
                    rxsh_d   = {rxsh_q[SPI_BITS_PER_BYTE-2:0], mosi_level};
                    bitcnt_d = bitcnt_q + SPI_CNT_W'(1);
                    if (bitcnt_q == LAST_BIT) begin
                        rx_data_d   = {rxsh_q[SPI_BITS_PER_BYTE-2:0], mosi_level};
                        rx_valid_d  = 1'b1;
                        byte_done_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (byte_done_q) begin
                        byte_done_d = 1'b0;
                        tx_load     = 1'b1;
                        txsh_d      = tx_byte;
                        miso_d      = tx_byte[7];
                    end else begin
                        txsh_d = {txsh_q[SPI_BITS_PER_BYTE-2:0], 1'b0};
                        miso_d = txsh_q[SPI_BITS_PER_BYTE-2];
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = (state_q == ACTIVE);
    assign cs_active   = (state_q == ACTIVE);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = tx_load;
    assign tx_underrun = tx_load & ~tx_valid;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: bit-banged mode-0 master, tx source queue, rx scoreboard.
module tb_spi_target;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       spi_clk, spi_mosi, spi_cs_n;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_underrun, cs_active;

    spi_target #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .cs_active   (cs_active)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rdy   = 0;
    int n_und   = 0;
    int n_rxv   = 0;
    int half_p  = 4;

    logic [7:0] exp_rx[$];
    logic [7:0] tx_src[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Monitor: counts handshakes, scores rx bytes, and plays the tx source queue.
    initial begin
        logic hs;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge sys_clk);
            hs = 1'b0;
            if (tx_ready) begin
                n_rdy++;
                hs = tx_valid;
            end
            if (tx_underrun) n_und++;
            if (rx_valid) begin
                n_rxv++;
                if (exp_rx.size() == 0) check_eq("rx_extra_pulse", {31'd0, rx_valid}, 32'd0);
                else                    check_eq("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            end
            @(posedge sys_clk);
            #1;
            if (hs && tx_src.size() > 0) void'(tx_src.pop_front());
            tx_valid = (tx_src.size() > 0);
            tx_data  = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic spi_bit(input logic mo, output logic mi);
        spi_mosi = mo;
        repeat (half_p) @(negedge sys_clk);
        mi = spi_miso;
        spi_clk = 1'b1;
        repeat (half_p) @(negedge sys_clk);
        spi_clk = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [7:0] mo, input logic [7:0] exp_mi);
        logic [7:0] mi;
        exp_rx.push_back(mo);
        for (int i = 7; i >= 0; i--) spi_bit(mo[i], mi[i]);
        check_eq(tag, {24'd0, mi}, {24'd0, exp_mi});
    endtask

    task automatic cs_low();
        @(negedge sys_clk);
        spi_cs_n = 1'b0;
        repeat (6) @(negedge sys_clk);
    endtask

    task automatic cs_high();
        repeat (half_p + 3) @(negedge sys_clk);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (8) @(negedge sys_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"},     {31'd0, spi_miso},    32'd0);
        check_eq({tag, "_oe"},       {31'd0, spi_miso_oe}, 32'd0);
        check_eq({tag, "_rx_data"},  {24'd0, rx_data},     32'd0);
        check_eq({tag, "_rx_valid"}, {31'd0, rx_valid},    32'd0);
        check_eq({tag, "_tx_ready"}, {31'd0, tx_ready},    32'd0);
        check_eq({tag, "_underrun"}, {31'd0, tx_underrun}, 32'd0);
        check_eq({tag, "_cs_act"},   {31'd0, cs_active},   32'd0);
    endtask

    initial begin
        int r0, u0, v0;
        logic dummy;
        logic [7:0] rnd_tx[$];
        logic [7:0] mo;

        sys_rst  = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check_reset_outputs("rst");
        sys_rst = 1'b0;
        repeat (10) @(negedge sys_clk);
        check_eq("idle_cs_active", {31'd0, cs_active}, 32'd0);

        // single byte, tx_valid held high
        r0 = n_rdy; u0 = n_und; v0 = n_rxv;
        tx_src.push_back(8'h3C); tx_src.push_back(8'h3C);
        cs_low();
        check_eq("t1_oe_active", {31'd0, spi_miso_oe}, 32'd1);
        xfer("t1_miso", 8'hA5, 8'h3C);
        cs_high();
        check_eq("t1_rx_hold", {24'd0, rx_data}, 32'hA5);
        check_eq("t1_ready_cnt", n_rdy - r0, 2);
        check_eq("t1_underrun_cnt", n_und - u0, 0);
        check_eq("t1_rxv_cnt", n_rxv - v0, 1);
        check_eq("t1_oe_idle", {31'd0, spi_miso_oe}, 32'd0);

        // burst of four; a fifth byte feeds the trailing handshake and is dropped
        r0 = n_rdy; u0 = n_und; v0 = n_rxv;
        for (int k = 0; k < 5; k++) tx_src.push_back(8'h10 + 8'(k));
        cs_low();
        for (int k = 0; k < 4; k++) xfer("t2_miso", 8'(k + 1), 8'h10 + 8'(k));
        cs_high();
        check_eq("t2_ready_cnt", n_rdy - r0, 5);
        check_eq("t2_underrun_cnt", n_und - u0, 0);
        check_eq("t2_rxv_cnt", n_rxv - v0, 4);
        tx_src.delete();

        // no tx data at all
        r0 = n_rdy; u0 = n_und; v0 = n_rxv;
        cs_low();
        xfer("t3_miso0", 8'hC3, 8'hFF);
        xfer("t3_miso1", 8'h3C, 8'hFF);
        cs_high();
        check_eq("t3_ready_cnt", n_rdy - r0, 3);
        check_eq("t3_underrun_cnt", n_und - u0, 3);
        check_eq("t3_rxv_cnt", n_rxv - v0, 2);

        // abort after 5 bits
        r0 = n_rdy; v0 = n_rxv;
        tx_src.push_back(8'h77);
        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, dummy);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_eq("t4_oe_drop", {31'd0, spi_miso_oe}, 32'd0);
        check_eq("t4_cs_active", {31'd0, cs_active}, 32'd0);
        repeat (8) @(negedge sys_clk);
        check_eq("t4_rxv_cnt", n_rxv - v0, 0);
        check_eq("t4_ready_cnt", n_rdy - r0, 1);
        tx_src.delete();
        v0 = n_rxv;
        tx_src.push_back(8'h42); tx_src.push_back(8'h42);
        cs_low();
        xfer("t4_miso_after", 8'h5A, 8'h42);
        cs_high();
        check_eq("t4_rxv_after", n_rxv - v0, 1);
        tx_src.delete();

        // reset mid-byte with CS held low
        tx_src.push_back(8'h66);
        cs_low();
        for (int i = 0; i < 3; i++) spi_bit(1'b1, dummy);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("t5_rst");
        sys_rst = 1'b0;
        tx_src.push_back(8'h55);
        r0 = n_rdy; v0 = n_rxv;
        for (int i = 0; i < 13; i++) spi_bit(1'b0, dummy);
        check_eq("t5_stuck_cs_act", {31'd0, cs_active}, 32'd0);
        check_eq("t5_stuck_oe", {31'd0, spi_miso_oe}, 32'd0);
        check_eq("t5_stuck_ready", n_rdy - r0, 0);
        check_eq("t5_stuck_rxv", n_rxv - v0, 0);
        cs_high();
        tx_src.delete();
        r0 = n_rdy; v0 = n_rxv;
        tx_src.push_back(8'h99); tx_src.push_back(8'h99);
        cs_low();
        xfer("t5_miso_after", 8'h77, 8'h99);
        cs_high();
        check_eq("t5_ready_after", n_rdy - r0, 2);
        check_eq("t5_rxv_after", n_rxv - v0, 1);
        tx_src.delete();

        // 256 random bytes at the minimum legal SCK phase
        half_p = 4;
        r0 = n_rdy; u0 = n_und; v0 = n_rxv;
        for (int k = 0; k < 257; k++) begin
            rnd_tx.push_back(8'($urandom_range(0, 255)));
            tx_src.push_back(rnd_tx[k]);
        end
        cs_low();
        for (int k = 0; k < 256; k++) begin
            mo = 8'($urandom_range(0, 255));
            xfer("t6_miso", mo, rnd_tx[k]);
        end
        cs_high();
        check_eq("t6_rxv_cnt", n_rxv - v0, 256);
        check_eq("t6_ready_cnt", n_rdy - r0, 257);
        check_eq("t6_underrun_cnt", n_und - u0, 0);
        check_eq("sb_drained", exp_rx.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
